sig_debounce: RTL

SIG_DEBOUNCE -- requirements
Module: sig_debounce

---
 rtl/sig_debounce_pkg.sv | 21 ++
 rtl/sig_debounce.sv | 135 +++++++++++++
 2 files changed

// File: rtl/sig_debounce_pkg.sv
// Shared types and helpers for the sig_debounce level debouncer.
// The FSM state encoding lives here so parents and benches can decode it.
package sig_debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_RISE_QUAL = 2'd1,
    S_HIGH      = 2'd2,
    S_FALL_QUAL = 2'd3
  } state_e;

  localparam int unsigned GLITCH_CNT_W = 16;

  // Width needed to hold 0..n, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sig_debounce.sv
// Debounces an already-synchronized level: a new level must hold STABLE_CYCLES
// edges before it is committed. Define SIG_DEBOUNCE_GLITCH_CNT_EN to add glitch_cnt.
module sig_debounce
  import sig_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i,
  output logic        o,
  output logic        o_posedge,
  output logic        o_negedge,
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
  output logic [15:0] glitch_cnt,
`endif
  output logic        o_busy
);

  localparam int unsigned       CW          = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0]     CNT_LAST    = CW'(STABLE_CYCLES - 1);
  localparam state_e            RESET_STATE = RESET_LEVEL ? S_HIGH : S_LOW;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          o_q, o_d;
  logic          pos_q, pos_d;
  logic          neg_q, neg_d;
  logic          busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      o_q     <= RESET_LEVEL;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    pos_d   = 1'b0;
    neg_d   = 1'b0;

    case (state_q)
      S_LOW: begin
        if (i) begin
          state_d = S_RISE_QUAL;
          cnt_d   = '0;
        end
      end
      S_RISE_QUAL: begin
        if (i) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_HIGH;
            o_d     = 1'b1;
            pos_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = S_LOW;
          cnt_d   = '0;
        end
      end
      S_HIGH: begin
        if (!i) begin
          state_d = S_FALL_QUAL;
          cnt_d   = '0;
        end
      end
      S_FALL_QUAL: begin
        if (!i) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_LOW;
            o_d     = 1'b0;
            neg_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
      end
    endcase

    // Busy is registered from the next state so it lines up with state_q.
    busy_d = (state_d == S_RISE_QUAL) || (state_d == S_FALL_QUAL);
  end

  assign o         = o_q;
  assign o_posedge = pos_q;
  assign o_negedge = neg_q;
  assign o_busy    = busy_q;

`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;
  logic                    glitch_hit;

  always_comb begin
    glitch_hit   = ((state_q == S_RISE_QUAL) && !i) ||
                   ((state_q == S_FALL_QUAL) &&  i);
    glitch_cnt_d = glitch_cnt_q;
    if (glitch_hit && (glitch_cnt_q != '1))
      glitch_cnt_d = glitch_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) glitch_cnt_q <= '0;
    else        glitch_cnt_q <= glitch_cnt_d;
  end

  assign glitch_cnt = glitch_cnt_q;
`endif

endmodule
